// File: rtl/modulo_transmissor_rolhas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modulo_transmissor_rolhas_pkg
// Description : Shared definitions for the cork transmitter: FSM state
//               encoding and the default largest accepted batch size.
// Revision    : 1.0 - initial release
// ============================================================================
package modulo_transmissor_rolhas_pkg;

   // Transmitter FSM states, 3-bit encoding
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PULSO      = 3'd1,
      ESPERA_ACK = 3'd2,
      INTERVALO  = 3'd3,
      CONCLUI    = 3'd4
   } estado_t;

   // Largest batch the operator may request; anything above is rejected
   localparam int MAX_LOTE_PADRAO = 99;

endpackage : modulo_transmissor_rolhas_pkg
`default_nettype wire

// File: rtl/modulo_transmissor_rolhas_temporizador.sv
`default_nettype none
// ============================================================================
// Module      : modulo_temporizador_rolhas
// Description : Loadable down-counter with zero flag. Load has priority over
//               decrement; the count saturates at zero.
// Revision    : 1.0 - initial release
// Ports       : clk      - clock
//               rst      - asynchronous reset, active-high (count cleared)
//               carga_i  - load valor_i into the counter
//               dec_i    - decrement by one (ignored when already zero)
//               valor_i  - load value
//               zero_o   - count is zero
// ============================================================================
module modulo_temporizador_rolhas #(
   parameter int LARGURA = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               carga_i,
   input  logic               dec_i,
   input  logic [LARGURA-1:0] valor_i,
   output logic               zero_o
);

   logic [LARGURA-1:0] cont_q;
   logic [LARGURA-1:0] cont_d;

   always_comb begin
      cont_d = cont_q;
      if (carga_i) begin
         cont_d = valor_i;
      end else if (dec_i && (cont_q != '0)) begin
         cont_d = cont_q - LARGURA'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

   assign zero_o = (cont_q == '0);

endmodule : modulo_temporizador_rolhas
`default_nettype wire

// File: rtl/modulo_transmissor_rolhas.sv
`default_nettype none
// ============================================================================
// Module      : modulo_transmissor_rolhas
// Description : Operator-side cork transmitter. Accepts a batch of N corks,
//               emits one cork strobe per cork, waits for a per-cork
//               acknowledge and reports remaining count, busy, done, error.
// Revision    : 1.0 - initial release
// Ports       : clk          - clock (clk_div domain)
//               rst          - asynchronous reset, active-high
//               start        - single-cycle batch request (IDLE only)
//               quantidade   - corks in the batch, sampled with start
//               ack          - receiver acknowledge of the current cork
//               abort        - operator cancel
//               pulso_rolha  - one-cycle cork strobe
//               restante     - corks not yet acknowledged
//               busy         - batch in progress
//               done         - one-cycle pulse at batch completion
//               erro         - sticky error (range, timeout or abort)
// ============================================================================
module modulo_transmissor_rolhas
   import modulo_transmissor_rolhas_pkg::*;
#(
   parameter int WIDTH       = 7,
   parameter int MAX_LOTE    = MAX_LOTE_PADRAO,
   parameter int GAP_CICLOS  = 2,
   parameter int TIMEOUT_ACK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] quantidade,
   input  logic             ack,
   input  logic             abort,
   output logic             pulso_rolha,
   output logic [WIDTH-1:0] restante,
   output logic             busy,
   output logic             done,
   output logic             erro
);

   localparam logic [WIDTH-1:0] c_max_lote      = WIDTH'(MAX_LOTE);
   // Timers are loaded with N-1 so that the zero flag rises on the Nth cycle
   localparam logic [3:0]       c_gap_carga     = 4'(GAP_CICLOS - 1);
   localparam logic [7:0]       c_timeout_carga = 8'(TIMEOUT_ACK - 1);

   estado_t          estado_q;
   estado_t          estado_d;
   logic [WIDTH-1:0] restante_q;
   logic [WIDTH-1:0] restante_d;
   logic             erro_q;
   logic             erro_d;

   logic             w_gap_zero;
   logic             w_tmo_zero;

   // Gap timer: held at its load value outside INTERVALO, counts inside it
   modulo_temporizador_rolhas #(
      .LARGURA (4)
   ) u_tmr_gap (
      .clk     (clk),
      .rst     (rst),
      .carga_i (estado_q != INTERVALO),
      .dec_i   (estado_q == INTERVALO),
      .valor_i (c_gap_carga),
      .zero_o  (w_gap_zero)
   );

   // Ack timeout: counts consecutive ack-low cycles while in ESPERA_ACK
   modulo_temporizador_rolhas #(
      .LARGURA (8)
   ) u_tmr_ack (
      .clk     (clk),
      .rst     (rst),
      .carga_i (estado_q != ESPERA_ACK),
      .dec_i   ((estado_q == ESPERA_ACK) && !ack),
      .valor_i (c_timeout_carga),
      .zero_o  (w_tmo_zero)
   );

   always_comb begin
      estado_d   = estado_q;
      restante_d = restante_q;
      erro_d     = erro_q;

      case (estado_q)
         IDLE: begin
            if (start) begin
               if (quantidade > c_max_lote) begin
                  erro_d = 1'b1;
               end else begin
                  restante_d = quantidade;
                  erro_d     = 1'b0;
                  estado_d   = (quantidade == '0) ? CONCLUI : PULSO;
               end
            end
         end
         PULSO: begin
            estado_d = ESPERA_ACK;
         end
         ESPERA_ACK: begin
            // Only ack seen here counts; ack during PULSO/INTERVALO is ignored
            if (ack) begin
               restante_d = restante_q - WIDTH'(1);
               estado_d   = (restante_q == WIDTH'(1)) ? CONCLUI : INTERVALO;
            end else if (w_tmo_zero) begin
               erro_d   = 1'b1;
               estado_d = IDLE;
            end
         end
         INTERVALO: begin
            if (w_gap_zero) begin
               estado_d = PULSO;
            end
         end
         CONCLUI: begin
            restante_d = '0;
            estado_d   = IDLE;
         end
         default: begin
            estado_d = IDLE;
         end
      endcase

      // Abort overrides everything above, including a same-cycle ack
      if (abort && (estado_q != IDLE)) begin
         estado_d   = IDLE;
         restante_d = restante_q;
         erro_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q   <= IDLE;
         restante_q <= '0;
         erro_q     <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         restante_q <= restante_d;
         erro_q     <= erro_d;
      end
   end

   // Decoded from the state register so reset clears them immediately
   assign pulso_rolha = (estado_q == PULSO);
   assign busy        = (estado_q != IDLE);
   assign done        = (estado_q == CONCLUI);
   assign restante    = restante_q;
   assign erro        = erro_q;

endmodule : modulo_transmissor_rolhas
`default_nettype wire

// File: tb/tb_modulo_transmissor_rolhas.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulo_transmissor_rolhas
// Description : Directed self-checking bench for modulo_transmissor_rolhas.
//               A receiver model returns ack with one quiet cycle after each
//               cork strobe (ack high two cycles after the strobe cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_transmissor_rolhas;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] quantidade = '0;
   logic       ack = 1'b0;
   logic       abort = 1'b0;
   logic       pulso_rolha;
   logic [6:0] restante;
   logic       busy;
   logic       done;
   logic       erro;

   modulo_transmissor_rolhas dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .quantidade  (quantidade),
      .ack         (ack),
      .abort       (abort),
      .pulso_rolha (pulso_rolha),
      .restante    (restante),
      .busy        (busy),
      .done        (done),
      .erro        (erro)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc, n_pulsos, n_done, n_acks, rx_max, abort_on_ack;
   int last_ack_cyc, done_cyc;
   int pulse_cyc[$];
   int pulse_rest[$];
   bit h1, h2, rx_en;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; afterwards we sit 1 time unit into the new cycle
   task automatic ciclo();
      bit a;
      @(posedge clk);
      #1;
      cyc++;
      a  = rx_en && h2 && (n_acks < rx_max);
      h2 = h1;
      h1 = pulso_rolha;
      ack   = a;
      abort = 1'b0;
      if (a) begin
         n_acks++;
         last_ack_cyc = cyc;
         if (n_acks == abort_on_ack) abort = 1'b1;
      end
      if (pulso_rolha) begin
         n_pulsos++;
         pulse_cyc.push_back(cyc);
         pulse_rest.push_back(int'(restante));
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   endtask

   task automatic clear_stats();
      cyc = 0; n_pulsos = 0; n_done = 0; n_acks = 0;
      last_ack_cyc = -1; done_cyc = -1;
      rx_max = 1000; abort_on_ack = 0; rx_en = 1'b1;
      h1 = 1'b0; h2 = 1'b0;
      pulse_cyc.delete();
      pulse_rest.delete();
   endtask

   task automatic lanca(input int q);
      quantidade = 7'(q);
      start = 1'b1;
      ciclo();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int i = 0;
      while (busy && i < budget) begin
         ciclo();
         i++;
      end
      check_val(tag, int'(busy), 0);
   endtask

   initial begin
      clear_stats();
      // Reset values
      ciclo();
      ciclo();
      check_val("rst_pulso", int'(pulso_rolha), 0);
      check_val("rst_restante", int'(restante), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_erro", int'(erro), 0);
      rst = 1'b0;
      ciclo();

      // 1: batch of 3, pulses 5 cycles apart, restante 3,2,1 at the strobes
      clear_stats();
      lanca(3);
      check_val("s1_first_pulse", int'(pulso_rolha), 1);
      check_val("s1_busy", int'(busy), 1);
      wait_idle(60, "s1_idle");
      check_val("s1_npulses", n_pulsos, 3);
      for (int i = 1; i < pulse_cyc.size(); i++)
         check_val("s1_spacing", pulse_cyc[i] - pulse_cyc[i-1], 5);
      for (int i = 0; i < pulse_rest.size(); i++)
         check_val("s1_restante_at_pulse", pulse_rest[i], 3 - i);
      check_val("s1_done_cycle", done_cyc, 14);
      check_val("s1_done_after_ack", done_cyc, last_ack_cyc + 1);
      check_val("s1_busy_fall", cyc, done_cyc + 1);
      check_val("s1_ndone", n_done, 1);
      check_val("s1_restante_end", int'(restante), 0);
      check_val("s1_erro", int'(erro), 0);

      // 2: out-of-range request, then a valid batch of 1 clears erro
      clear_stats();
      lanca(100);
      check_val("s2_erro", int'(erro), 1);
      check_val("s2_busy", int'(busy), 0);
      check_val("s2_restante", int'(restante), 0);
      repeat (5) ciclo();
      check_val("s2_no_pulses", n_pulsos, 0);
      clear_stats();
      lanca(1);
      check_val("s2b_erro_clear", int'(erro), 0);
      check_val("s2b_pulse", int'(pulso_rolha), 1);
      wait_idle(30, "s2b_idle");
      check_val("s2b_npulses", n_pulsos, 1);
      check_val("s2b_ndone", n_done, 1);

      // 3: ack withheld after the 2nd cork -> timeout after 8 cycles
      clear_stats();
      rx_max = 2;
      lanca(5);
      wait_idle(80, "s3_idle");
      check_val("s3_erro", int'(erro), 1);
      check_val("s3_restante", int'(restante), 3);
      check_val("s3_ndone", n_done, 0);
      check_val("s3_npulses", n_pulsos, 3);
      check_val("s3_timeout_len", cyc - pulse_cyc[$], 9);

      // 4: abort in the same cycle as the 2nd ack
      clear_stats();
      abort_on_ack = 2;
      lanca(4);
      check_val("s4_erro_cleared", int'(erro), 0);
      wait_idle(60, "s4_idle");
      check_val("s4_restante", int'(restante), 3);
      check_val("s4_erro", int'(erro), 1);
      repeat (10) ciclo();
      check_val("s4_npulses", n_pulsos, 2);
      check_val("s4_ndone", n_done, 0);
      check_val("s4_busy", int'(busy), 0);

      // 5: zero-cork batch -> immediate done, erro cleared
      clear_stats();
      lanca(0);
      check_val("s5_done", int'(done), 1);
      check_val("s5_busy", int'(busy), 1);
      check_val("s5_erro", int'(erro), 0);
      check_val("s5_pulso", int'(pulso_rolha), 0);
      ciclo();
      check_val("s5_done_low", int'(done), 0);
      check_val("s5_busy_low", int'(busy), 0);
      check_val("s5_ndone", n_done, 1);
      check_val("s5_npulses", n_pulsos, 0);

      // 6: asynchronous reset mid-INTERVALO with restante=7
      clear_stats();
      lanca(9);
      begin
         int i = 0;
         while (!(restante == 7'd7 && !pulso_rolha && busy) && i < 60) begin
            ciclo();
            i++;
         end
      end
      check_val("s6_reach_restante", int'(restante), 7);
      #2 rst = 1'b1;
      #1;
      check_val("s6_pulso", int'(pulso_rolha), 0);
      check_val("s6_restante", int'(restante), 0);
      check_val("s6_busy", int'(busy), 0);
      check_val("s6_done", int'(done), 0);
      check_val("s6_erro", int'(erro), 0);
      #1 rst = 1'b0;
      clear_stats();
      repeat (10) ciclo();
      check_val("s6_no_pulses", n_pulsos, 0);
      check_val("s6_idle", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_modulo_transmissor_rolhas
`default_nettype wire

// File: doc/modulo_transmissor_rolhas.md
Name: modulo_transmissor_rolhas

Overview:
Operator-side cork transmitter; sending end of the cork-entry pulse interface that the filling/sealing top level counts on its cork-entry counter.
- Accepts a batch request of N corks (0..99).
- Emits one cork pulse per cork, waits for a per-cork acknowledge from the receiver, and reports remaining count, busy, done and error.
- Sits between the operator keypad logic and the secondary cork buffer; runs on the divided clock clk_div.

Parameters:
- WIDTH, 7, width of the quantity and remaining-count buses.
- MAX_LOTE, 99, largest accepted batch; larger requests are rejected.
- GAP_CICLOS, 2, idle cycles forced between consecutive cork pulses (range 1..15).
- TIMEOUT_ACK, 8, cycles to wait for ack before aborting the batch (range 1..255).

Ports:
- clk  input  1  system clock (clk_div domain)
- rst  input  1  asynchronous reset, active-high
- start  input  1  single-cycle batch request; sampled only in IDLE
- quantidade  input  WIDTH  corks in the batch; sampled with start
- ack  input  1  receiver acknowledge of the current cork (level, one or more cycles)
- abort  input  1  operator cancel; synchronous, highest priority after rst
- pulso_rolha  output  1  one-cycle cork strobe to the receiver
- restante  output  WIDTH  corks not yet acknowledged
- busy  output  1  high from start acceptance until return to IDLE
- done  output  1  one-cycle pulse when the last cork is acknowledged
- erro  output  1  sticky error flag; cleared by the next accepted start or by rst

Behaviour:
- Reset (async, rst=1), all outputs and state forced immediately:
  - state=IDLE
  - pulso_rolha=0, restante=0, busy=0, done=0, erro=0
  - gap and timeout counters cleared
- States:
  - IDLE
  - PULSO: pulso_rolha=1 for exactly one cycle
  - ESPERA_ACK
  - INTERVALO: GAP_CICLOS cycles
  - CONCLUI: done=1 for one cycle
- IDLE, start=1:
  - quantidade=0: no pulses; next cycle CONCLUI (done pulse); erro cleared.
  - quantidade>MAX_LOTE: stay IDLE, erro=1, restante unchanged, no pulses.
  - Otherwise: restante<=quantidade, erro<=0, busy<=1, next state PULSO.
  - First pulso_rolha appears the cycle after start is accepted (latency 1).
- PULSO -> ESPERA_ACK unconditionally.
- ESPERA_ACK:
  - ack=1: restante decrements by 1 in that cycle. Then restante==1 (becoming 0) goes to CONCLUI; otherwise INTERVALO.
  - ack=0 for TIMEOUT_ACK consecutive cycles: erro=1, go to IDLE, busy=0, restante holds the unacknowledged count, no done pulse.
  - ack already high in the cycle pulso_rolha is asserted is ignored. Only ack seen in ESPERA_ACK counts, so one ack level counts exactly one cork.
- INTERVALO:
  - Counts GAP_CICLOS cycles, then goes to PULSO.
  - ack during INTERVALO is ignored.
- CONCLUI: done=1, busy=1; next cycle IDLE with busy=0 and restante=0.
- abort=1 in any non-IDLE state:
  - Next state IDLE, busy=0, no further pulses, restante holds, erro=1.
  - abort in the same cycle as an ack: abort wins and no decrement occurs.
- start outside IDLE is ignored; no queuing.
- Reset mid-batch: immediate return to reset values. A pulse in flight is truncated and no done pulse is produced.
- Arithmetic:
  - restante is unsigned WIDTH bits and never wraps; a decrement at 0 is impossible by construction.
  - The comparison quantidade>MAX_LOTE uses the full WIDTH bits.
- Cork pulse rate per cork is at most 1 pulse per (3+GAP_CICLOS) cycles, assuming ack returns 1 cycle after the pulse.

Decomposition:
- Shared package:
  - state encoding constants (IDLE, PULSO, ESPERA_ACK, INTERVALO, CONCLUI) as a 3-bit typedef
  - MAX_LOTE default value of 99, shared with the top-level out-of-range check (>99)
- Natural sub-module: modulo_temporizador_rolhas, a loadable down-counter with zero flag. Instantiated twice, once for the gap timer and once for the ack timeout.

Test Plan:
1. rst pulse, then start with quantidade=3 and ack returned 1 cycle after each pulse:
   - exactly 3 pulses, spaced 5 cycles apart with GAP_CICLOS=2
   - restante goes 3,2,1,0
   - done high one cycle after the 3rd ack; busy falls the following cycle
2. start with quantidade=100 -> no pulses, erro=1, busy stays 0; then start with quantidade=1 and ack -> erro clears, 1 pulse, done asserted.
3. start with quantidade=5, ack withheld after the 2nd pulse -> after 8 cycles erro=1, busy=0, restante=3, no done.
4. start with quantidade=4, abort asserted in the same cycle as the 2nd ack -> restante=3, erro=1, IDLE, no further pulses.
5. start with quantidade=0 -> zero pulses, done pulses once on the next cycle, erro=0.
6. rst asserted asynchronously mid-INTERVALO with restante=7 -> all outputs 0 immediately, no pulse after rst release until a new start.
